// File: rtl/if_id_decode_pkg.sv
// Shared MIPS opcode/funct encodings and the decoded instruction-class bundle
// used by the IF/ID stage.
package if_id_decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  typedef struct packed {
    logic rt;
    logic addi;
    logic andi;
    logic lw;
    logic sw;
    logic j;
    logic jal;
    logic jr;
    logic beq;
    logic bne;
    logic illegal;
  } dec_flags_t;

endpackage

// File: rtl/if_id_decode_opcode_decode.sv
// Combinational opcode/funct classifier: exactly one class flag or illegal is
// set for every input pattern.
module opcode_decode
  import if_id_decode_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  output dec_flags_t  dec
);

  always_comb begin
    dec = '0;
    case (op)
      OP_RTYPE: begin
        if (funct == FUNCT_JR) dec.jr = 1'b1;
        else                   dec.rt = 1'b1;
      end
      OP_ADDI: dec.addi    = 1'b1;
      OP_ANDI: dec.andi    = 1'b1;
      OP_LW:   dec.lw      = 1'b1;
      OP_SW:   dec.sw      = 1'b1;
      OP_J:    dec.j       = 1'b1;
      OP_JAL:  dec.jal     = 1'b1;
      OP_BEQ:  dec.beq     = 1'b1;
      OP_BNE:  dec.bne     = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/if_id_decode.sv
// IF/ID pipeline register with registered one-hot instruction-class flags,
// stall/flush control and a saturating illegal-instruction counter.
module if_id_decode
  import if_id_decode_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DW-1:0]    inst_in,
  input  logic [DW-1:0]    pc4_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             stall,
  input  logic             flush,
  output logic [DW-1:0]    inst_q,
  output logic [DW-1:0]    pc4_q,
  output logic             valid_q,
  output logic             RT,
  output logic             addi,
  output logic             andi,
  output logic             lw,
  output logic             sw,
  output logic             j,
  output logic             jal,
  output logic             jr,
  output logic             beq,
  output logic             bne,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  dec_flags_t dec_next;
  dec_flags_t dec_q;

  // Decode the incoming instruction so the flags land in the same cycle as inst_q.
  opcode_decode u_opcode_decode (
    .op    (inst_in[31:26]),
    .funct (inst_in[5:0]),
    .dec   (dec_next)
  );

  assign in_ready = ~stall | flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q      <= '0;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
      dec_q       <= '0;
      illegal_cnt <= '0;
    end else if (flush) begin
      inst_q  <= '0;
      valid_q <= 1'b0;
      dec_q   <= '0;
    end else if (!stall) begin
      inst_q  <= inst_in;
      pc4_q   <= pc4_in;
      valid_q <= in_valid;
      dec_q   <= in_valid ? dec_next : '0;
      if (in_valid && dec_next.illegal && (illegal_cnt != '1))
        illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

  assign RT      = dec_q.rt;
  assign addi    = dec_q.addi;
  assign andi    = dec_q.andi;
  assign lw      = dec_q.lw;
  assign sw      = dec_q.sw;
  assign j       = dec_q.j;
  assign jal     = dec_q.jal;
  assign jr      = dec_q.jr;
  assign beq     = dec_q.beq;
  assign bne     = dec_q.bne;
  assign illegal = dec_q.illegal;

endmodule
